ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//   Instruction prefetch stage sitting directly upstream of execute. Owns the
//   fetch PC and issues one-outstanding read requests to instruction memory.
//   Buffers returned words in a small FIFO and presents them with their PC to
//   execute through a valid/ready handshake.
//   A redirect from execute (taken branch/jump) flushes the queue and restarts
//   fetching at the new PC.
// PARAMETERS
//   DEPTH     4             queue entries; power of 2, >= 2
//   RESET_PC  32'h00000000  fetch PC loaded on reset
// PORTS
//   clk          in   1   clock, rising edge
//   rstd         in   1   reset, asynchronous, active-low
//   mem_req      out  1   read request to instruction memory
//   mem_addr     out  32  byte address of request, word-aligned
//   mem_ack      in   1   1-cycle pulse: mem_rdata valid for current request
//   mem_rdata    in   32  instruction word returned
//   ins_valid    out  1   head entry valid
//   ins          out  32  head instruction
//   ins_pc       out  32  byte PC of head instruction
//   ins_ready    in   1   execute consumes head this cycle
//   redirect     in   1   flush queue and refetch from redirect_pc
//   redirect_pc  in   32  new fetch PC; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//   Reset (rstd=0, async): fetch_pc=RESET_PC, mem_req=0, mem_addr=RESET_PC,
//     count=0, ins_valid=0, ins=0, ins_pc=0, drop=0. Effect immediate, no clock.
//   Request side: FSM {IDLE, WAIT}.
//     IDLE: if count < DEPTH (after this edge's pop): mem_req<=1,
//       mem_addr<=fetch_pc, go WAIT.
//     WAIT: mem_req, mem_addr held stable until the edge sampling mem_ack=1.
//       On ack, if drop=0: push {mem_rdata, mem_addr}, fetch_pc+=4.
//       On ack, if drop=1: discard data, clear drop.
//       If space remains after the push, the same edge re-issues mem_req=1
//       with the next address (back-to-back, no bubble). Otherwise go IDLE.
//     Memory latency >= 1 cycle: ack is never sampled on the same edge that
//       raised mem_req.
//   Space rule: entry reserved at issue; never issue when count+inflight=DEPTH,
//     so a push never overflows.
//   Queue: ins/ins_pc/ins_valid driven from head register, not comb from mem.
//     Pop when ins_valid & ins_ready. Push+pop on the same edge: count unchanged.
//     Pop on empty queue: ignored.
//     Minimum latency: mem_ack edge -> ins_valid high the following cycle.
//   Redirect (sampled at edge, highest priority):
//     count<=0, ins_valid<=0, fetch_pc<={redirect_pc[31:2],2'b00}.
//     If WAIT with no ack on this edge: drop<=1, request held until its ack.
//     If ack on the same edge: the returned data is discarded.
//     Next request goes out at redirect_pc once the old request has completed.
//     Pop and push on the redirect edge are discarded.
//   Wrap-around: fetch_pc+4 wraps modulo 2^32; pointers wrap modulo DEPTH.
//   rstd low mid-transaction: all state cleared; a late mem_ack arriving after
//     reset with mem_req=0 is ignored.
// TESTING
//   1 Reset release, mem acks 1 cycle after each req, ins_ready=1 -> mem_addr
//     0,4,8,...; ins_pc 0,4,8 in order with matching ins; never a duplicate.
//   2 ins_ready=0, DEPTH=4 -> exactly 4 pushes, then mem_req=0. Raise
//     ins_ready -> fetch resumes at addr 16; pops return 0,4,8,12 in order.
//   3 Redirect to 32'h100 while WAIT at addr 8, ack 3 cycles later -> word 8
//     discarded; next mem_addr=32'h100; first ins_pc=32'h100.
//   4 Redirect on the same edge as mem_ack and a pop -> queue empty, data
//     dropped, next request at redirect_pc.
//   5 Full queue plus simultaneous pop and ack -> count stays DEPTH,
//     no overflow, FIFO order kept.
//   6 rstd pulled low mid-WAIT -> mem_req=0, ins_valid=0 immediately; after
//     release, fetch restarts at RESET_PC; stray mem_ack has no effect.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps one read outstanding to
// instruction memory and hands buffered words with their PC to execute.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_n;
  logic [31:0]   mem_addr_n;
  logic          mem_req_n;
  logic          drop;
  logic          drop_n;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [CW-1:0] count_pop;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_n;
  logic [AW-1:0] wr_ptr_n;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          ins_valid_n;
  logic [31:0]   ins_n;
  logic [31:0]   ins_pc_n;
  logic          pop;
  logic          ack;
  logic          push;
  logic          issue;
  logic [31:0]   redir_pc;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // State register.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: a request is issued only when no read is in flight after this
  // edge and the post-edge occupancy leaves a free slot for its data.
  always_comb begin
    pop       = ins_valid & ins_ready & ~redirect;
    ack       = (state == WAIT) & mem_ack;
    push      = ack & ~drop & ~redirect;
    count_pop = count - CW'(pop);
    if (redirect) begin
      count_n = {CW{1'b0}};
    end else begin
      count_n = count_pop + CW'(push);
    end
    issue   = ((state == IDLE) | ack) & (count_n < DEPTH_C);
    state_n = IDLE;
    case (state)
      IDLE:    state_n = issue ? WAIT : IDLE;
      WAIT:    state_n = (ack & ~issue) ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end

  // Output/datapath next values; fetch_pc is always the address of the next
  // word to be accepted into the queue.
  always_comb begin
    redir_pc = {redirect_pc[31:2], 2'b00};
    if (redirect) begin
      fetch_pc_n = redir_pc;
    end else if (push) begin
      fetch_pc_n = fetch_pc + 32'd4;
    end else begin
      fetch_pc_n = fetch_pc;
    end
    mem_addr_n = issue ? fetch_pc_n : mem_addr;
    mem_req_n  = (state_n == WAIT);
    if (redirect && (state == WAIT) && !mem_ack) begin
      drop_n = 1'b1;
    end else if (ack) begin
      drop_n = 1'b0;
    end else begin
      drop_n = drop;
    end
    if (redirect) begin
      rd_ptr_n = {AW{1'b0}};
      wr_ptr_n = {AW{1'b0}};
    end else begin
      rd_ptr_n = rd_ptr + AW'(pop);
      wr_ptr_n = wr_ptr + AW'(push);
    end
    ins_valid_n = (count_n != {CW{1'b0}});
    // A push into an otherwise empty queue bypasses storage into the head.
    if (ins_valid_n && (count_pop == {CW{1'b0}})) begin
      ins_n    = mem_rdata;
      ins_pc_n = mem_addr;
    end else if (ins_valid_n) begin
      ins_n    = data_q[rd_ptr_n];
      ins_pc_n = pc_q[rd_ptr_n];
    end else begin
      ins_n    = ins;
      ins_pc_n = ins_pc;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      fetch_pc  <= RESET_PC;
      mem_req   <= 1'b0;
      mem_addr  <= RESET_PC;
      drop      <= 1'b0;
      count     <= {CW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      ins_valid <= 1'b0;
      ins       <= 32'h0000_0000;
      ins_pc    <= 32'h0000_0000;
    end else begin
      fetch_pc  <= fetch_pc_n;
      mem_req   <= mem_req_n;
      mem_addr  <= mem_addr_n;
      drop      <= drop_n;
      count     <= count_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      ins_valid <= ins_valid_n;
      ins       <= ins_n;
      ins_pc    <= ins_pc_n;
    end
  end

  // Queue storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= mem_addr;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a one-cycle memory responder plus manual
// ack sequences for redirect and reset corner cases.
module tb_ifetch_queue;

  logic        clk;
  logic        rstd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          checks = 0;
  int          errors = 0;
  logic        mem_en = 1'b0;
  logic [31:0] got_pc [$];
  logic [31:0] got_ins [$];
  logic [31:0] acked [$];

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rstd       (rstd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ins_valid  (ins_valid),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_ready  (ins_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Record the head that will be consumed at the coming edge, then advance.
  task automatic tick();
    if (rstd && ins_valid && ins_ready && !redirect) begin
      got_pc.push_back(ins_pc);
      got_ins.push_back(ins);
    end
    @(negedge clk);
  endtask

  task automatic ack_now();
    mem_ack   = 1'b1;
    mem_rdata = ~mem_addr;
    tick();
    mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    mem_en    = 1'b0;
    ins_ready = 1'b0;
    redirect  = 1'b0;
    rstd      = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, ins_valid}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0000_0000);
    @(negedge clk);
    mem_ack = 1'b0;
    got_pc.delete();
    got_ins.delete();
    acked.delete();
    @(negedge clk);
  endtask

  // Memory model: acks every request one cycle after it appears; data = ~addr.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          mem_ack   = 1'b1;
          mem_rdata = ~mem_addr;
          acked.push_back(mem_addr);
        end
      end
    end
  end

  initial begin
    rstd        = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1;
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    chk("reset_valid", {31'd0, ins_valid}, 32'd0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_ins", ins, 32'h0);
    chk("reset_ins_pc", ins_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Streaming with ready held high.
    mem_en    = 1'b1;
    ins_ready = 1'b1;
    rstd      = 1'b1;
    repeat (14) tick();
    for (int i = 0; i < 6; i++) begin
      chk("t1_addr", qget(acked, i), 32'(4 * i));
      chk("t1_pc", qget(got_pc, i), 32'(4 * i));
      chk("t1_ins", qget(got_ins, i), ~32'(4 * i));
    end

    // Stall until full, simultaneous pop+ack, refill, then drain.
    do_reset();
    mem_en = 1'b1;
    rstd   = 1'b1;
    repeat (10) tick();
    chk("t2_pushes", 32'(acked.size()), 32'd4);
    chk("t2_req_stop", {31'd0, mem_req}, 32'd0);
    chk("t2_head", ins_pc, 32'h0);
    ins_ready = 1'b1;
    tick();
    tick();
    ins_ready = 1'b0;
    repeat (6) tick();
    chk("t5_pushes", 32'(acked.size()), 32'd6);
    chk("t5_req_stop", {31'd0, mem_req}, 32'd0);
    chk("t5_head", ins_pc, 32'h8);
    chk("t5_resume", qget(acked, 4), 32'h10);
    ins_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 9; i++) begin
      chk("t5_pc", qget(got_pc, i), 32'(4 * i));
      chk("t5_ins", qget(got_ins, i), ~32'(4 * i));
    end

    // Redirect while waiting on addr 8; the late ack is dropped.
    do_reset();
    rstd = 1'b1;
    tick();
    chk("t3_req0", mem_addr, 32'h0);
    ack_now();
    ack_now();
    chk("t3_wait8", mem_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("t3_flush", {31'd0, ins_valid}, 32'd0);
    chk("t3_held_req", {31'd0, mem_req}, 32'd1);
    chk("t3_held_addr", mem_addr, 32'h8);
    tick();
    tick();
    ack_now();
    chk("t3_drop_valid", {31'd0, ins_valid}, 32'd0);
    chk("t3_new_addr", mem_addr, 32'h100);
    ack_now();
    chk("t3_valid", {31'd0, ins_valid}, 32'd1);
    chk("t3_pc", ins_pc, 32'h100);
    chk("t3_ins", ins, ~32'h100);

    // Redirect, ack and pop on the same edge.
    ins_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    mem_ack     = 1'b1;
    mem_rdata   = ~mem_addr;
    tick();
    redirect  = 1'b0;
    mem_ack   = 1'b0;
    ins_ready = 1'b0;
    chk("t4_empty", {31'd0, ins_valid}, 32'd0);
    chk("t4_req", {31'd0, mem_req}, 32'd1);
    chk("t4_addr", mem_addr, 32'h200);
    chk("t4_nopop", 32'(got_pc.size()), 32'd0);
    ack_now();
    chk("t4_pc", ins_pc, 32'h200);
    chk("t4_next", mem_addr, 32'h204);

    // Reset mid-WAIT with a stray ack at release.
    rstd = 1'b0;
    #1;
    chk("t6_req", {31'd0, mem_req}, 32'd0);
    chk("t6_valid", {31'd0, ins_valid}, 32'd0);
    chk("t6_addr", mem_addr, 32'h0);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    rstd      = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t6_stray", {31'd0, ins_valid}, 32'd0);
    chk("t6_restart", mem_addr, 32'h0);
    chk("t6_req_up", {31'd0, mem_req}, 32'd1);
    tick();
    chk("t6_still_empty", {31'd0, ins_valid}, 32'd0);
    ack_now();
    chk("t6_pc", ins_pc, 32'h0);
    chk("t6_ins", ins, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
